// File: rtl/synth_pkg.sv
// ----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synth datapath and its PWM output stage.
//   Sample_t                   : signed two's-complement mixed sample
//   DEF_SAMPLE_WIDTH           : default sample width
//   DEF_PWM_BITS               : default PWM counter width (period = 2**PWM_BITS)
//   DEF_PERIODS_PER_SAMPLE     : default number of PWM periods per sample
// ----------------------------------------------------------------------------
package synth_pkg;

    localparam int DEF_SAMPLE_WIDTH       = 24;
    localparam int DEF_PWM_BITS           = 8;
    localparam int DEF_PERIODS_PER_SAMPLE = 4;

    typedef logic [DEF_SAMPLE_WIDTH-1:0] Sample_t;

endpackage

// File: rtl/pwm_output_if.sv
// ----------------------------------------------------------------------------
// pwm_output_if
// Valid/ready sample bus between the sample producer and pwm_output.
//   i_Sample       : signed sample from the producer
//   i_SampleValid  : producer holds i_Sample valid until accepted
//   o_SampleReady  : consumer holding buffer is empty; accept = valid & ready
// Modports: master = producer side, slave = pwm_output side.
// ----------------------------------------------------------------------------
interface pwm_output_if #(
    parameter int SAMPLE_WIDTH = synth_pkg::DEF_SAMPLE_WIDTH
);
    logic [SAMPLE_WIDTH-1:0] i_Sample;
    logic                    i_SampleValid;
    logic                    o_SampleReady;

    modport master (
        output i_Sample,
        output i_SampleValid,
        input  o_SampleReady
    );

    modport slave (
        input  i_Sample,
        input  i_SampleValid,
        output o_SampleReady
    );
endinterface

// File: rtl/pwm_modulator.sv
// ----------------------------------------------------------------------------
// pwm_modulator
// Free-running PWM counter with registered compare output.
//   i_Clock       : clock, rising edge
//   i_Reset       : synchronous active-high reset
//   i_Duty        : high clocks per period (2**PWM_BITS-1 max, 0 = always low)
//   o_Pwm         : registered pin, o_Pwm(t+1) = (cnt(t) < duty(t))
//   o_PeriodTick  : high on the last count of each period (cnt == max)
// ----------------------------------------------------------------------------
module pwm_modulator #(
    parameter int PWM_BITS = synth_pkg::DEF_PWM_BITS
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    input  logic [PWM_BITS-1:0] i_Duty,
    output logic                o_Pwm,
    output logic                o_PeriodTick
);

    logic [PWM_BITS-1:0] r_cnt;
    logic                r_pwm;

    assign o_PeriodTick = (r_cnt == {PWM_BITS{1'b1}});
    assign o_Pwm        = r_pwm;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            // Natural wrap max -> 0 gives the 2**PWM_BITS period.
            r_cnt <= r_cnt + PWM_BITS'(1);
            r_pwm <= (r_cnt < i_Duty);
        end
    end

endmodule

// File: rtl/pwm_output.sv
// ----------------------------------------------------------------------------
// pwm_output
// Converts a signed sample stream into a 1-bit PWM pin for an RC filter.
// A one-entry buffer decouples the producer; samples are taken from it at
// sample boundaries. First-order error feedback across PWM periods adds
// sub-LSB resolution to the duty cycle.
//   i_Clock     : clock, rising edge
//   i_Reset     : synchronous active-high reset
//   sample_if   : slave side of the valid/ready sample bus
//   o_Pwm       : registered PWM pin
//   o_Underrun  : 1-cycle pulse when a sample boundary finds the buffer empty
//                 (only once running)
// ----------------------------------------------------------------------------
module pwm_output
    import synth_pkg::*;
#(
    parameter int SAMPLE_WIDTH       = DEF_SAMPLE_WIDTH,
    parameter int PWM_BITS           = DEF_PWM_BITS,
    parameter int PERIODS_PER_SAMPLE = DEF_PERIODS_PER_SAMPLE
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    pwm_output_if.slave  sample_if,
    output logic         o_Pwm,
    output logic         o_Underrun
);

    localparam int ERR_W = SAMPLE_WIDTH - PWM_BITS;
    localparam int PC_W  = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [SAMPLE_WIDTH-1:0] r_buf;
    logic                    r_buf_valid;
    logic                    r_ready;
    logic [SAMPLE_WIDTH-1:0] r_cur_sample;
    logic [ERR_W-1:0]        r_err;
    logic [PWM_BITS-1:0]     r_duty;
    logic [PC_W-1:0]         r_period_cnt;
    logic [0:0]              r_state;
    logic                    r_underrun;

    logic                    w_period_tick;
    logic                    w_last_period;
    logic                    w_boundary;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_buf_valid_next;
    logic [SAMPLE_WIDTH-1:0] w_sample_eff;
    logic [SAMPLE_WIDTH-1:0] w_offset;
    logic [SAMPLE_WIDTH:0]   w_acc;

    pwm_modulator #(
        .PWM_BITS (PWM_BITS)
    ) u_modulator (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Duty       (r_duty),
        .o_Pwm        (o_Pwm),
        .o_PeriodTick (w_period_tick)
    );

    assign w_last_period = (r_period_cnt == PC_W'(PERIODS_PER_SAMPLE - 1));
    assign w_boundary    = w_period_tick & w_last_period;
    assign w_accept      = sample_if.i_SampleValid & r_ready;
    assign w_load        = w_boundary & r_buf_valid;

    // Accept and load never coincide: ready is low whenever the buffer is full.
    assign w_buf_valid_next = w_accept | (r_buf_valid & ~w_load);

    // The duty computed at a boundary must already see the sample being loaded.
    assign w_sample_eff = w_load ? r_buf : r_cur_sample;

    // Flip the sign bit: signed two's complement -> offset binary, 0 -> mid-scale.
    assign w_offset = {~w_sample_eff[SAMPLE_WIDTH-1], w_sample_eff[SAMPLE_WIDTH-2:0]};
    assign w_acc    = {1'b0, w_offset} + {{(PWM_BITS + 1){1'b0}}, r_err};

    assign sample_if.o_SampleReady = r_ready;
    assign o_Underrun              = r_underrun;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_buf        <= '0;
            r_buf_valid  <= 1'b0;
            r_ready      <= 1'b0;
            r_cur_sample <= '0;
            r_err        <= '0;
            r_duty       <= {1'b1, {(PWM_BITS - 1){1'b0}}};
            r_period_cnt <= '0;
            r_state      <= ST_PRIME;
            r_underrun   <= 1'b0;
        end else begin
            r_buf_valid <= w_buf_valid_next;
            r_ready     <= ~w_buf_valid_next;
            if (w_accept) begin
                r_buf <= sample_if.i_SampleValid ? sample_if.i_Sample : r_buf;
            end

            if (w_load) begin
                r_cur_sample <= r_buf;
            end

            if (w_period_tick) begin
                r_period_cnt <= w_last_period ? '0 : (r_period_cnt + PC_W'(1));
            end

            if (w_load) begin
                r_state <= ST_RUN;
            end

            r_underrun <= w_boundary & ~r_buf_valid & (r_state == ST_RUN);

            // The new duty is registered here and is in place at cnt = 0 of the
            // next period; the carry-out case pins the duty at full scale and
            // drops the residue rather than wrapping to a tiny duty.
            if (w_period_tick) begin
                if (w_acc[SAMPLE_WIDTH]) begin
                    r_duty <= {PWM_BITS{1'b1}};
                    r_err  <= '0;
                end else begin
                    r_duty <= w_acc[SAMPLE_WIDTH-1 -: PWM_BITS];
                    r_err  <= w_acc[ERR_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_output.sv
// ----------------------------------------------------------------------------
// tb_pwm_output
// Directed bench for pwm_output with default parameters (256-clock PWM period,
// 1024-clock sample period). cyc mirrors the position in the PWM timeline:
// cyc % 256 is the counter value of the current cycle, and period p drives the
// pin during cycles 256p+1 .. 256p+256.
// ----------------------------------------------------------------------------
module tb_pwm_output;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;
    logic o_Pwm;
    logic o_Underrun;

    int cyc        = 0;
    int ur_count   = 0;
    int ur_last    = -1;
    int n_checks   = 0;
    int n_errors   = 0;
    int acc_a;
    int acc_b;
    int acc_x;

    pwm_output_if #(.SAMPLE_WIDTH(24)) sample_if ();

    pwm_output #(
        .SAMPLE_WIDTH       (24),
        .PWM_BITS           (8),
        .PERIODS_PER_SAMPLE (4)
    ) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .sample_if  (sample_if.slave),
        .o_Pwm      (o_Pwm),
        .o_Underrun (o_Underrun)
    );

    always #5 i_Clock = ~i_Clock;

    always @(posedge i_Clock) begin
        if (i_Reset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(negedge i_Clock) begin
        if (o_Underrun) begin
            ur_count = ur_count + 1;
            ur_last  = cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        if (cyc > n) check("wait_late", cyc, n);
        while (cyc < n) @(negedge i_Clock);
    endtask

    task automatic measure(input string tag, input int p, input int exp_high);
        int highs;
        highs = 0;
        wait_cyc(256 * p + 1);
        for (int i = 0; i < 256; i++) begin
            highs = highs + int'(o_Pwm);
            @(negedge i_Clock);
        end
        $display("period %0d: %0d high clocks", p, highs);
        check(tag, highs, exp_high);
    endtask

    // Presents a sample and holds it until the negedge at which ready is seen;
    // the following posedge performs the accept. acc = cyc of that cycle.
    task automatic send(input logic [23:0] s, output int acc);
        acc = -1;
        sample_if.i_Sample      = s;
        sample_if.i_SampleValid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (sample_if.o_SampleReady) begin
                acc = cyc;
                break;
            end
            @(negedge i_Clock);
        end
        if (acc < 0) check("send_timeout", 0, 1);
        else @(negedge i_Clock);
        sample_if.i_SampleValid = 1'b0;
        $display("send 0x%06h accepted in cycle %0d", s, acc);
    endtask

    initial begin
        sample_if.i_Sample      = '0;
        sample_if.i_SampleValid = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(negedge i_Clock);
        check("rst_pwm", int'(o_Pwm), 0);
        check("rst_underrun", int'(o_Underrun), 0);
        check("rst_ready", int'(sample_if.o_SampleReady), 0);
        i_Reset = 1'b0;

        // Idle after reset: mid-scale duty, no underrun while priming.
        wait_cyc(1);
        check("idle_ready", int'(sample_if.o_SampleReady), 1);
        for (int p = 0; p < 4; p++) measure("idle_duty", p, 128);
        wait_cyc(2100);
        check("idle_no_underrun", ur_count, 0);

        // Positive full scale, loaded at boundary 3071.
        send(24'h7FFFFF, acc_x);
        check("ready_drops", int'(sample_if.o_SampleReady), 0);
        wait_cyc(3070);
        check("ready_low_wait", int'(sample_if.o_SampleReady), 0);
        wait_cyc(3072);
        check("ready_after_load", int'(sample_if.o_SampleReady), 1);
        send(24'h800000, acc_x);
        measure("fullscale_p14", 14, 255);
        measure("fullscale_p15", 15, 255);
        measure("negscale_p16", 16, 0);
        check("no_underrun_fed", ur_count, 0);

        // Sub-LSB value: duty dithers 128/129.
        send(24'h008000, acc_x);
        measure("dither_p20", 20, 128);
        measure("dither_p21", 21, 129);
        measure("dither_p22", 22, 128);
        measure("dither_p23", 23, 129);

        // Starved: underrun at boundary 6143, duty continues on old sample.
        measure("starve_p24", 24, 128);
        measure("starve_p25", 25, 129);
        check("underrun_count", ur_count, 1);
        check("underrun_cycle", ur_last, 6144);

        // Back-to-back samples: second waits for the next boundary.
        send(24'h400000, acc_a);
        send(24'hC00000, acc_b);
        check("b2b_first_before_bound", int'(acc_a < 7167), 1);
        check("b2b_second_accept", acc_b, 7168);
        measure("b2b_a_p28", 28, 192);
        measure("b2b_a_p31", 31, 192);
        measure("b2b_b_p32", 32, 64);
        check("b2b_no_underrun", ur_count, 1);

        // Reset with the buffer full: buffered sample must be discarded.
        send(24'h7FFFFF, acc_x);
        check("buf_full_ready", int'(sample_if.o_SampleReady), 0);
        wait_cyc(8600);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        check("mid_rst_pwm", int'(o_Pwm), 0);
        check("mid_rst_underrun", int'(o_Underrun), 0);
        check("mid_rst_ready", int'(sample_if.o_SampleReady), 0);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        wait_cyc(1);
        check("post_rst_ready", int'(sample_if.o_SampleReady), 1);
        for (int p = 0; p < 5; p++) measure("post_rst_duty", p, 128);
        check("post_rst_no_underrun", ur_count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
